// File: rtl/button_pulsegen.sv
// Operator push-button front end: synchronise, debounce and turn each accepted
// press into a one-cycle command pulse, with at most one command per cycle.
module button_pulsegen #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_step_phase,
    input  logic       btn_step_inst,
    output logic       run,
    output logic       step_phase,
    output logic       step_inst,
    output logic [2:0] btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int CH_RUN   = 0;
    localparam int CH_PHASE = 1;
    localparam int CH_INST  = 2;

    logic [2:0] w_raw;
    logic [2:0] w_deb;
    logic [2:0] w_press_req;
    logic [2:0] w_grant;
    logic [2:0] r_pulse;

    assign w_raw = {btn_step_inst, btn_step_phase, btn_run};

    for (genvar g = 0; g < 3; g++) begin : g_chan
        logic          r_s1;
        logic          r_s2;
        logic          r_deb;
        logic [CW-1:0] r_cnt;
        logic          w_at_limit;

        // The synchronised level has disagreed with the accepted level long enough.
        assign w_at_limit = (r_s2 != r_deb) && (r_cnt == CNT_LAST);

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours (the s1->s2 chain relies on it).
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_deb <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (w_at_limit) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end

        assign w_deb[g]       = r_deb;
        assign w_press_req[g] = w_at_limit && r_s2;
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_grant = '0;
        if (w_press_req[CH_PHASE]) begin
            w_grant[CH_PHASE] = 1'b1;
        end else if (w_press_req[CH_INST]) begin
            w_grant[CH_INST] = 1'b1;
        end else if (w_press_req[CH_RUN]) begin
            w_grant[CH_RUN] = 1'b1;
        end
    end

    // Losing requests are dropped; the pulse register lines up with the deb flip.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_grant;
        end
    end

    assign run        = r_pulse[CH_RUN];
    assign step_phase = r_pulse[CH_PHASE];
    assign step_inst  = r_pulse[CH_INST];
    assign btn_level  = w_deb;

endmodule

// File: doc/button_pulsegen.md
# button_pulsegen

Front-end conditioner for the three operator push-buttons (run, step-phase, step-instruction). It synchronises each raw button to `clock`, debounces it, and converts each accepted press into a single-cycle pulse. It drives the `run`, `step_phase` and `step_inst` inputs of the phase generator directly. It guarantees at most one command pulse per cycle, so the phase generator never sees competing commands.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive cycles a synchronised level must differ from the accepted level before it is accepted. Legal range is 2..2^20. Use 16 for simulation; set per board for silicon.
- `clock`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `btn_run`  input  1  raw run button, active-high, asynchronous to `clock`, may bounce.
- `btn_step_phase`  input  1  raw step-phase button, same properties.
- `btn_step_inst`  input  1  raw step-instruction button, same properties.
- `run`  output  1  registered single-cycle pulse: accepted press of `btn_run`.
- `step_phase`  output  1  registered single-cycle pulse: accepted press of `btn_step_phase`.
- `step_inst`  output  1  registered single-cycle pulse: accepted press of `btn_step_inst`.
- `btn_level`  output  3  debounced levels {step_inst, step_phase, run}, bit 0 = run; registered.

## Operation
- There are three identical channels. Each channel has:
  - a 2-flop synchroniser (`s1`, `s2`);
  - an accepted level `deb`;
  - a counter `cnt`, width clog2(DEBOUNCE_CYCLES)+1.
- Counter rule, each edge:
  - if `s2 == deb`: `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= s2`, `cnt <= 0`;
  - else: `cnt <= cnt+1`.
- Any return of `s2` to `deb` before the limit discards progress. Glitches shorter than `DEBOUNCE_CYCLES` cycles at `s2` are therefore never accepted.
- A press request is raised for a channel in the cycle its `deb` is about to flip 0→1. A 1→0 flip (release) generates no pulse.
- Arbitration when several requests coincide in one cycle:
  - priority is `step_phase` > `step_inst` > `run`;
  - only the winner's output pulses;
  - losers are dropped, not queued;
  - all channels' `deb` still update normally.
- Outputs are registered. Each pulse lasts exactly one cycle. A new pulse on the same channel requires release accepted (`deb` back to 0) followed by a new accepted press, so holding a button yields exactly one pulse.
- Reset values: `s1`, `s2`, `deb`, `cnt` = 0; `run`, `step_phase`, `step_inst` = 0; `btn_level` = 3'b000.
- Reset mid-debounce aborts the in-progress count. A button held through reset release is treated as a fresh press and yields one pulse after the full latency.

## Timing
- Let E0 be the first rising edge that samples a raw input high, with the input stable from then on.
  - After E0: `s1` = 1.
  - After E0+1: `s2` = 1.
  - `cnt` increments at E0+2 … E0+DEBOUNCE_CYCLES.
  - At E0+DEBOUNCE_CYCLES+1: `deb` and the output pulse both go high.
- The pulse is high for exactly the one cycle following E0+DEBOUNCE_CYCLES+1. `btn_level` bit rises at the same edge.
- Release latency is identical (DEBOUNCE_CYCLES+2 edges) and affects only `btn_level`.
- `reset` assertion clears all outputs immediately and asynchronously. Deassertion takes effect at the next edge; deassertion is assumed synchronised externally.
- No combinational path from any input to any output.

## Test plan
- **Clean press.** DEBOUNCE_CYCLES=4; `btn_run` 0→1 before E0, held 20 cycles. Required: `run` = 1 only in the cycle after E0+5; `btn_level[0]` = 1 from E0+5; no further `run` pulse while held.
- **Bounce rejection.** DEBOUNCE_CYCLES=4; `btn_step_inst` toggles 1,0,1,1,0 per cycle, then stays 1. Required: no pulse during the bounce; exactly one `step_inst` pulse, 6 edges after the final rising sample.
- **Simultaneous press.** All three buttons rise in the same cycle, clean. Required: only `step_phase` pulses, in the cycle after E0+5; `btn_level` = 3'b111 at that edge; `run` and `step_inst` stay 0 throughout.
- **Release and re-press.**
  - `btn_run` held 10 cycles, released 10 cycles, pressed again.
  - Required: two `run` pulses; `btn_level[0]` falls 6 edges after the release sample; no pulse on the release.
  - Variant: release shorter than 4 cycles. Required: no second pulse.
- **Reset mid-operation.**
  - Assert `reset` 2 cycles after E0 with `btn_step_phase` held, then release `reset`.
  - Required: outputs 0 immediately on assertion; one `step_phase` pulse 6 edges after the first post-reset edge.
- **Glitch filter.** Single-cycle high pulses on `btn_run`, repeated every 3 cycles for 50 cycles. Required: `run` and `btn_level[0]` remain 0.
